// File: rtl/farrow_phase_scheduler_pkg.sv
// Shared types, defaults and the phase-to-filter-row mapping for the Farrow phase scheduler.
`default_nettype none

package farrow_pkg;

  localparam int unsigned FARROW_FILTERS_DEF = 40;
  localparam int unsigned FARROW_TAPS_DEF    = 6;
  localparam int unsigned FARROW_PHASE_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    CHECK = 3'd2,
    MAC   = 3'd3,
    OUT   = 3'd4
  } sched_state_t;

  // Row index = floor(frac * filters / 2^phase_w); frac < 1.0 keeps it below filters.
  function automatic int unsigned phase_to_filter(input logic [31:0] frac,
                                                  input int unsigned filters,
                                                  input int unsigned phase_w);
    logic [63:0] prod;
    prod = {32'd0, frac} * {32'd0, filters};
    return 32'(prod >> phase_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/farrow_phase_scheduler_acc.sv
// Fractional-phase accumulator: clear / add step / subtract one, integer flag and filter row.
`default_nettype none

module farrow_phase_acc
  import farrow_pkg::*;
#(
  parameter int unsigned FILTERS = FARROW_FILTERS_DEF,
  parameter int unsigned PHASE_W = FARROW_PHASE_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       add_i,
  input  logic                       sub_i,
  input  logic [PHASE_W+1:0]         step_i,
  output logic                       ge_one_o,
  output logic [PHASE_W-1:0]         frac_o,
  output logic [$clog2(FILTERS)-1:0] filter_o
);

  localparam int unsigned ACC_W = PHASE_W + 3;
  localparam int unsigned FI_W  = $clog2(FILTERS);
  localparam logic [ACC_W-1:0] ONE = {3'b001, {PHASE_W{1'b0}}};

  logic [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + {1'b0, step_i};
    end else if (sub_i) begin
      acc_d = acc_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign ge_one_o = |acc_q[ACC_W-1:PHASE_W];
  assign frac_o   = acc_q[PHASE_W-1:0];
  assign filter_o = FI_W'(phase_to_filter(32'(acc_q[PHASE_W-1:0]), FILTERS, PHASE_W));

endmodule

`default_nettype wire

// File: rtl/farrow_phase_scheduler.sv
// Farrow polyphase interpolator sequencer: FSM, tap counter and handshakes.
// Optional FARROW_SCHED_STATS_EN adds saturating output/starvation counters.
`default_nettype none

module farrow_phase_scheduler
  import farrow_pkg::*;
#(
  parameter int unsigned FILTERS = FARROW_FILTERS_DEF,
  parameter int unsigned TAPS    = FARROW_TAPS_DEF,
  parameter int unsigned PHASE_W = FARROW_PHASE_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [PHASE_W+1:0]         cfg_step,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [$clog2(FILTERS)-1:0] coef_filter,
  output logic [$clog2(TAPS)-1:0]    coef_tap,
  output logic                       mac_en,
  output logic                       mac_clr,
  output logic                       mac_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PHASE_W-1:0]         out_mu
`ifdef FARROW_SCHED_STATS_EN
 ,output logic [31:0]                stat_outputs,
  output logic [31:0]                stat_starve
`endif
);

  localparam int unsigned FI_W   = $clog2(FILTERS);
  localparam int unsigned TAP_W  = $clog2(TAPS);
  localparam int unsigned FILL_W = $clog2(TAPS + 1);
  localparam logic [PHASE_W+1:0] STEP_MIN = {{(PHASE_W+1){1'b0}}, 1'b1};

  sched_state_t        state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [TAP_W-1:0]    tap_q, tap_d;
  logic [PHASE_W+1:0]  step_q, step_d;

  logic                acc_clr, acc_add, acc_sub;
  logic                acc_ge_one;
  logic [PHASE_W-1:0]  acc_frac;
  logic [FI_W-1:0]     acc_filter;
  logic [FILL_W-1:0]   fill_inc;

  farrow_phase_acc #(
    .FILTERS (FILTERS),
    .PHASE_W (PHASE_W)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (acc_clr),
    .add_i    (acc_add),
    .sub_i    (acc_sub),
    .step_i   (step_q),
    .ge_one_o (acc_ge_one),
    .frac_o   (acc_frac),
    .filter_o (acc_filter)
  );

  assign fill_inc = fill_q + FILL_W'(1);

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    tap_d       = tap_q;
    step_d      = step_q;
    acc_clr     = 1'b0;
    acc_add     = 1'b0;
    acc_sub     = 1'b0;
    in_ready    = 1'b0;
    mac_en      = 1'b0;
    mac_clr     = 1'b0;
    mac_last    = 1'b0;
    out_valid   = 1'b0;
    coef_tap    = '0;
    coef_filter = '0;
    out_mu      = '0;

    case (state_q)
      IDLE: begin
        if (en) begin
          step_d  = (cfg_step == '0) ? STEP_MIN : cfg_step;
          state_d = FILL;
        end
      end

      FILL: begin
        if (!en) begin
          state_d = IDLE;
          fill_d  = '0;
          acc_clr = 1'b1;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            fill_d = fill_inc;
            if (fill_inc == FILL_W'(TAPS)) begin
              state_d = CHECK;
            end
          end
        end
      end

      CHECK: begin
        if (!en) begin
          state_d = IDLE;
          fill_d  = '0;
          acc_clr = 1'b1;
        end else if (acc_ge_one) begin
          // Integer part still pending: drain one input per accepted sample.
          in_ready = 1'b1;
          acc_sub  = in_valid;
        end else begin
          state_d = MAC;
          tap_d   = '0;
        end
      end

      MAC: begin
        mac_en      = 1'b1;
        coef_tap    = tap_q;
        coef_filter = acc_filter;
        mac_clr     = (tap_q == '0);
        mac_last    = (tap_q == TAP_W'(TAPS - 1));
        if (mac_last) begin
          state_d = OUT;
          tap_d   = '0;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end

      OUT: begin
        out_valid = 1'b1;
        out_mu    = acc_frac;
        if (out_ready) begin
          if (en) begin
            acc_add = 1'b1;
            state_d = CHECK;
          end else begin
            acc_clr = 1'b1;
            fill_d  = '0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fill_q  <= '0;
      tap_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      tap_q   <= tap_d;
      step_q  <= step_d;
    end
  end

`ifdef FARROW_SCHED_STATS_EN
  logic [31:0] outputs_q;
  logic [31:0] starve_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outputs_q <= '0;
      starve_q  <= '0;
    end else if (en) begin
      if (out_valid && out_ready && (outputs_q != '1)) begin
        outputs_q <= outputs_q + 32'd1;
      end
      if ((state_q == FILL || state_q == CHECK) && in_ready && !in_valid &&
          (starve_q != '1)) begin
        starve_q <= starve_q + 32'd1;
      end
    end
  end

  assign stat_outputs = outputs_q;
  assign stat_starve  = starve_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_farrow_phase_scheduler.sv
// Directed self-checking bench for farrow_phase_scheduler (default parameters 40/6/16).
`default_nettype none

module tb_farrow_phase_scheduler;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [17:0] cfg_step;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  coef_filter;
  logic [2:0]  coef_tap;
  logic        mac_en;
  logic        mac_clr;
  logic        mac_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_mu;
`ifdef FARROW_SCHED_STATS_EN
  logic [31:0] stat_outputs;
  logic [31:0] stat_starve;
`endif

  int vectors    = 0;
  int miscompares = 0;

  farrow_phase_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cfg_step    (cfg_step),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .coef_filter (coef_filter),
    .coef_tap    (coef_tap),
    .mac_en      (mac_en),
    .mac_clr     (mac_clr),
    .mac_last    (mac_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mu      (out_mu)
`ifdef FARROW_SCHED_STATS_EN
   ,.stat_outputs(stat_outputs),
    .stat_starve (stat_starve)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed per-output expectations: inputs accepted since the previous
  // output, filter row and out_mu. Rows: step 1.0, 0.5, 2.0, 1.5, 0 (clamped to 1 LSB).
  int steps   [5]    = '{32'h10000, 32'h08000, 32'h20000, 32'h18000, 32'h00000};
  int exp_acc [5][6] = '{'{6,1,1,1,1,1}, '{6,0,1,0,1,0}, '{6,2,2,2,2,2},
                         '{6,1,2,1,2,1}, '{6,0,0,0,0,0}};
  int exp_flt [5][6] = '{'{0,0,0,0,0,0}, '{0,20,0,20,0,20}, '{0,0,0,0,0,0},
                         '{0,20,0,20,0,20}, '{0,0,0,0,0,0}};
  int exp_mu  [5][6] = '{'{0,0,0,0,0,0}, '{0,32768,0,32768,0,32768}, '{0,0,0,0,0,0},
                         '{0,32768,0,32768,0,32768}, '{0,1,2,3,4,5}};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [17:0] step);
    en        = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cfg_step  = step;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  // Runs until one output is accepted (out_ready assumed high); collects observations only.
  task automatic get_output(input bit gap, output int acc_n, output int filt, output int mu,
                            output int starve, output bit seq_ok, output bit timeout);
    int exp_tap;
    bit prev_last;
    bit done;
    acc_n = 0; filt = -1; mu = -1; starve = 0; seq_ok = 1'b1;
    exp_tap = 0; prev_last = 1'b0; done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (in_valid && in_ready) acc_n++;
      if (in_ready && !in_valid) starve++;
      if (prev_last && !out_valid) seq_ok = 1'b0;
      if (mac_en) begin
        if (exp_tap == 0) filt = int'(coef_filter);
        if (int'(coef_tap) != exp_tap || mac_clr != (exp_tap == 0) ||
            mac_last != (exp_tap == 5) || int'(coef_filter) != filt || in_ready || out_valid)
          seq_ok = 1'b0;
        exp_tap++;
      end
      prev_last = mac_en && mac_last;
      if (out_valid) begin
        if (exp_tap != 6 || in_ready) seq_ok = 1'b0;
        mu   = int'(out_mu);
        done = 1'b1;
      end
      tick();
      if (gap) in_valid = ~in_valid;
      if (done) break;
    end
    timeout = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1; cfg_step = 18'h10000;
    repeat (3) tick();
    vectors++;
    if ({in_ready, mac_en, mac_clr, mac_last, out_valid, coef_filter, coef_tap, out_mu} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, want 0",
               {in_ready, mac_en, mac_clr, mac_last, out_valid, coef_filter, coef_tap, out_mu});
    end
    en = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_ready: in_ready=%b want 0", in_ready);
    end
    en = 1'b1;
    repeat (2) tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_rates();
    int a, f, m, s;
    bit ok, to;
    for (int r = 0; r < 5; r++) begin
      start(18'(steps[r]));
      for (int k = 0; k < 6; k++) begin
        get_output(1'b0, a, f, m, s, ok, to);
        if (k == 0) cfg_step = 18'h3FFFF;
        vectors++;
        if (to !== 1'b0) begin
          miscompares++;
          $display("FAIL rate_timeout r%0d o%0d: no output within budget", r, k);
        end
        vectors++;
        if (a !== exp_acc[r][k]) begin
          miscompares++;
          $display("FAIL rate_accepts r%0d o%0d: got %0d want %0d", r, k, a, exp_acc[r][k]);
        end
        vectors++;
        if (f !== exp_flt[r][k]) begin
          miscompares++;
          $display("FAIL rate_filter r%0d o%0d: got %0d want %0d", r, k, f, exp_flt[r][k]);
        end
        vectors++;
        if (m !== exp_mu[r][k]) begin
          miscompares++;
          $display("FAIL rate_mu r%0d o%0d: got %h want %h", r, k, m, exp_mu[r][k]);
        end
        vectors++;
        if (ok !== 1'b1) begin
          miscompares++;
          $display("FAIL rate_tap_seq r%0d o%0d: got %b want 1", r, k, ok);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int a, f, m, s;
    bit ok, to, seen;
    start(18'h08000);
    get_output(1'b0, a, f, m, s, ok, to);
    out_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_timeout: out_valid not seen, got %b want 1", seen);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({out_valid, out_mu, mac_en, in_ready} !== {1'b1, 16'h8000, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold c%0d: valid=%b mu=%h mac_en=%b in_ready=%b want 1/8000/0/0",
                 i, out_valid, out_mu, mac_en, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_valid: got %b want 1", out_valid);
    end
    tick();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_resume: valid/in_ready got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid_mac();
    bit seen;
    int a;
    start(18'h10000);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (mac_en && coef_tap == 3'd3) seen = 1'b1;
      else tick();
    end
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_mac_timeout: tap 3 not seen, got %b want 1", seen);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mac_en, out_valid, in_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL mid_mac_reset: mac_en/valid/ready got %b want 000", {mac_en, out_valid, in_ready});
    end
    tick();
    rst_n = 1'b1;
    a = 0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (mac_en) seen = 1'b1;
      else begin
        if (in_valid && in_ready) a++;
        tick();
      end
    end
    vectors++;
    if (seen !== 1'b1 || a !== 6) begin
      miscompares++;
      $display("FAIL refill_accepts: got %0d (mac seen %b) want 6", a, seen);
    end
  endtask

  task automatic test_en_drop();
    int a, f, m, s;
    bit ok, to, seen;
    start(18'h08000);
    get_output(1'b0, a, f, m, s, ok, to);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (mac_en) seen = 1'b1;
      else tick();
    end
    en = 1'b0;
    seen = 1'b0;
    m = -1;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (out_valid) begin
        seen = 1'b1;
        m = int'(out_mu);
      end
      tick();
    end
    vectors++;
    if (seen !== 1'b1 || m !== 32'h8000) begin
      miscompares++;
      $display("FAIL en_drop_completes: seen=%b mu=%h want 1/8000", seen, m);
    end
    repeat (2) tick();
    vectors++;
    if ({in_ready, mac_en, out_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL en_drop_idle: ready/mac/valid got %b want 000", {in_ready, mac_en, out_valid});
    end
    en = 1'b1;
    get_output(1'b0, a, f, m, s, ok, to);
    vectors++;
    if (to !== 1'b0 || a !== 6 || m !== 0) begin
      miscompares++;
      $display("FAIL en_restart: timeout=%b accepts=%0d mu=%h want 0/6/0", to, a, m);
    end
  endtask

`ifdef FARROW_SCHED_STATS_EN
  task automatic test_stats();
    int a, f, m, s, starve_sum, tos;
    bit ok, to;
    start(18'h10000);
    starve_sum = 0;
    tos = 0;
    for (int k = 0; k < 100; k++) begin
      get_output(1'b1, a, f, m, s, ok, to);
      starve_sum += s;
      if (to) tos++;
    end
    vectors++;
    if (tos !== 0) begin
      miscompares++;
      $display("FAIL stats_timeout: %0d outputs timed out, want 0", tos);
    end
    vectors++;
    if (stat_outputs !== 32'd100) begin
      miscompares++;
      $display("FAIL stat_outputs: got %0d want 100", stat_outputs);
    end
    vectors++;
    if (stat_starve !== 32'(starve_sum)) begin
      miscompares++;
      $display("FAIL stat_starve: got %0d want %0d", stat_starve, starve_sum);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_step = '0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_rates();
    test_backpressure();
    test_reset_mid_mac();
    test_en_drop();
`ifdef FARROW_SCHED_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
